sysid_check_ctrl: RTL

- Avalon-MM read master that sequences the 2-word system-ID slave: word 0 holds the system ID, word 1 holds the build timestamp.
- Reads both words and compares them against expected values.
- Publishes the results as status flags for the boot firmware and the board LEDs.
- Sits between the system-ID slave port and the boot/status logic; retries on bus stalls.

---
 rtl/sysid_check_ctrl_if.sv | 22 ++
 rtl/sysid_check_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read channel between the system-ID checker (master) and the
// 2-word system-ID slave.
interface sysid_check_ctrl_if;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );
endinterface

// File: rtl/sysid_check_ctrl.sv
// Reads the system ID and build timestamp from the system-ID slave, compares
// them against the expected values and publishes pass/fail/timeout status.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRY      = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    sysid_check_ctrl_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic                id_ok,
    output logic                ts_ok,
    output logic                timeout_err,
    output logic [31:0]         id_value,
    output logic [31:0]         ts_value,
    output logic [1:0]          retry_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        CMP
    } state_t;

    localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);
    localparam logic [1:0] LAT_LAST    = 2'(READ_LATENCY - 1);
    localparam bit         ZERO_LAT    = (READ_LATENCY == 0);

    state_t      state_q, state_d;
    logic [7:0]  stall_q, stall_d;
    logic [1:0]  lat_q, lat_d;
    logic [1:0]  retry_q, retry_d;
    logic        gap_q, gap_d;
    logic        auto_q, auto_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        tmo_q, tmo_d;
    logic [31:0] id_val_q, id_val_d;
    logic [31:0] ts_val_q, ts_val_d;
    logic        read_active;

    // gap_q blanks the read strobe for the one cycle after a timeout so the
    // slave sees the aborted read released before the retry starts.
    assign read_active   = ((state_q == RD_ID) || (state_q == RD_TS)) && !gap_q;
    assign bus.m_read    = read_active;
    assign bus.m_address = (state_q == RD_TS);

    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = tmo_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;
    assign retry_count = retry_q;

    always_comb begin
        state_d  = state_q;
        stall_d  = stall_q;
        lat_d    = lat_q;
        retry_d  = retry_q;
        gap_d    = 1'b0;
        auto_d   = auto_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        tmo_d    = tmo_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;

        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    auto_d  = 1'b0;
                    busy_d  = 1'b1;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    tmo_d   = 1'b0;
                    retry_d = 2'd0;
                    stall_d = 8'd0;
                    lat_d   = 2'd0;
                    state_d = RD_ID;
                end
            end

            RD_ID, RD_TS: begin
                if (read_active) begin
                    if (bus.m_waitrequest) begin
                        if (stall_q + 8'd1 == STALL_LIMIT) begin
                            stall_d = 8'd0;
                            if (retry_q < RETRY_LIMIT) begin
                                retry_d = retry_q + 2'd1;
                                gap_d   = 1'b1;
                                state_d = RD_ID;
                            end else begin
                                tmo_d   = 1'b1;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            stall_d = stall_q + 8'd1;
                        end
                    end else begin
                        stall_d = 8'd0;
                        lat_d   = 2'd0;
                        if (ZERO_LAT) begin
                            if (state_q == RD_ID) begin
                                id_val_d = bus.m_readdata;
                                state_d  = RD_TS;
                            end else begin
                                ts_val_d = bus.m_readdata;
                                state_d  = CMP;
                            end
                        end else begin
                            state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
                        end
                    end
                end
            end

            LAT_ID: begin
                if (lat_q == LAT_LAST) begin
                    id_val_d = bus.m_readdata;
                    state_d  = RD_TS;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            LAT_TS: begin
                if (lat_q == LAT_LAST) begin
                    ts_val_d = bus.m_readdata;
                    state_d  = CMP;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            CMP: begin
                id_ok_d = (id_val_q == EXPECTED_ID);
                ts_ok_d = (ts_val_q == EXPECTED_TS);
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            stall_q  <= 8'd0;
            lat_q    <= 2'd0;
            retry_q  <= 2'd0;
            gap_q    <= 1'b0;
            auto_q   <= AUTO_START;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            tmo_q    <= 1'b0;
            id_val_q <= 32'd0;
            ts_val_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            lat_q    <= lat_d;
            retry_q  <= retry_d;
            gap_q    <= gap_d;
            auto_q   <= auto_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            tmo_q    <= tmo_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

endmodule
